// File: rtl/muldiv_coprocessor.sv
// HI/LO multiply/divide coprocessor: single-cycle MULT/MULTU/MTHI/MTLO and a
// 32-iteration restoring divider that stalls the core while a divide is in flight.
module muldiv_coprocessor #(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [2:0]  md__opcode,
  input  logic        md__active,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] md__rd_data,
  output logic        md__stall,
  output logic        md__busy
);

  localparam logic [2:0] OP_MFHI  = 3'd0;
  localparam logic [2:0] OP_MFLO  = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_MULTU = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_DIVU  = 3'd7;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FIXUP  = 2'd2;

  logic [1:0]  state_reg;
  logic [4:0]  count_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] quo_reg, rem_reg, divisor_reg, dividend_reg;
  logic        quo_neg_reg, rem_neg_reg, div_zero_reg;

  logic [63:0] prod_s, prod_u;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] shifted;
  logic        trial_ok;
  logic [31:0] quo_next, rem_next;
  logic [31:0] quo_fix, rem_fix;

  assign md__busy  = (state_reg != IDLE);
  assign md__stall = md__active & md__busy;

  assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // DIVU sees both operands as non-negative, so only DIV produces signs.
  assign rs_neg = (md__opcode == OP_DIV) & rs_data[31];
  assign rt_neg = (md__opcode == OP_DIV) & rt_data[31];
  assign rs_mag = rs_neg ? (32'd0 - rs_data) : rs_data;
  assign rt_mag = rt_neg ? (32'd0 - rt_data) : rt_data;

  // One restoring step; a set bit 32 always means the trial subtraction fits.
  assign shifted  = {rem_reg, quo_reg[31]};
  assign trial_ok = shifted[32] | (shifted[31:0] >= divisor_reg);
  assign rem_next = trial_ok ? (shifted[31:0] - divisor_reg) : shifted[31:0];
  assign quo_next = {quo_reg[30:0], trial_ok};

  assign quo_fix = quo_neg_reg ? (32'd0 - quo_reg) : quo_reg;
  assign rem_fix = rem_neg_reg ? (32'd0 - rem_reg) : rem_reg;

  always_comb begin
    md__rd_data = 'x;
    if (state_reg == IDLE)
      md__rd_data = (md__opcode == OP_MFHI) ? hi_reg : lo_reg;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg    <= IDLE;
      count_reg    <= 5'd0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      quo_reg      <= 32'd0;
      rem_reg      <= 32'd0;
      divisor_reg  <= 32'd0;
      dividend_reg <= 32'd0;
      quo_neg_reg  <= 1'b0;
      rem_neg_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (md__active) begin
            case (md__opcode)
              OP_MTHI:  hi_reg <= rs_data;
              OP_MTLO:  lo_reg <= rs_data;
              OP_MULT:  {hi_reg, lo_reg} <= prod_s;
              OP_MULTU: {hi_reg, lo_reg} <= prod_u;
              OP_DIV, OP_DIVU: begin
                divisor_reg  <= rt_mag;
                quo_reg      <= rs_mag;
                rem_reg      <= 32'd0;
                count_reg    <= 5'd31;
                quo_neg_reg  <= rs_neg ^ rt_neg;
                rem_neg_reg  <= rs_neg;
                div_zero_reg <= (rt_data == 32'd0);
                dividend_reg <= rs_data;
                state_reg    <= DIVIDE;
              end
              default: ;
            endcase
          end
        end
        DIVIDE: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          if (count_reg == 5'd0)
            state_reg <= FIXUP;
          else
            count_reg <= count_reg - 5'd1;
        end
        FIXUP: begin
          // Divide-by-zero overrides the sign fixup entirely.
          lo_reg    <= div_zero_reg ? DIV_ZERO_LO : quo_fix;
          hi_reg    <= div_zero_reg ? dividend_reg : rem_fix;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_coprocessor.sv
// Scoreboard bench for muldiv_coprocessor: stimulus queues expected MFHI/MFLO
// data, a negedge monitor pops and compares whenever a read is accepted.
module tb_muldiv_coprocessor;

  localparam logic [2:0] OP_MFHI  = 3'd0;
  localparam logic [2:0] OP_MFLO  = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_MULTU = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_DIVU  = 3'd7;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [2:0]  md__opcode = 3'd0;
  logic        md__active = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] md__rd_data;
  logic        md__stall;
  logic        md__busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  muldiv_coprocessor dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .md__opcode (md__opcode),
    .md__active (md__active),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .md__rd_data(md__rd_data),
    .md__stall  (md__stall),
    .md__busy   (md__busy)
  );

  always #5 clk = ~clk;

  // Monitor: a read is accepted when active, not stalled, MF opcode.
  always @(negedge clk) begin
    if (rst_b && md__active && !md__stall &&
        (md__opcode == OP_MFHI || md__opcode == OP_MFLO)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read op=%0d got=%h expected=<none>", md__opcode, md__rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (md__rd_data !== e) begin
          failures++;
          $display("FAIL read op=%0d got=%h expected=%h", md__opcode, md__rd_data, e);
        end else
          $display("read op=%0d data=%h ok", md__opcode, md__rd_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end else
      $display("check %s value=%h ok", name, got);
  endtask

  // Present an op and hold it until the edge that accepts it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic st;
    int guard;
    md__active = 1'b1;
    md__opcode = op;
    rs_data    = a;
    rt_data    = b;
    guard      = 0;
    do begin
      @(negedge clk);
      st = md__stall;
      @(posedge clk);
      #1;
      guard++;
    end while (st && guard < 100);
    if (st) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout op=%0d got=stalled expected=accepted", op);
    end
    md__active = 1'b0;
  endtask

  task automatic read_expect(input logic [2:0] op, input logic [31:0] want);
    exp_q.push_back(want);
    issue(op, 32'd0, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } div_vec_t;

  div_vec_t dv[5];

  initial begin
    int stall_cnt;
    int busy_cnt;
    int guard;

    dv[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    dv[1] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    dv[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    dv[3] = '{OP_DIVU, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5};
    dv[4] = '{OP_DIV,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, md__busy}, 32'd0);
    check("reset_stall", {31'd0, md__stall}, 32'd0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    read_expect(OP_MFHI, 32'd0);
    read_expect(OP_MFLO, 32'd0);

    // Multiplies
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    read_expect(OP_MFHI, 32'hFFFF_FFFF);
    read_expect(OP_MFLO, 32'hFFFF_FFFA);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    read_expect(OP_MFHI, 32'd2);
    read_expect(OP_MFLO, 32'hFFFF_FFFA);

    // DIVU 100/7 with MFLO issued one cycle after the accept edge
    issue(OP_DIVU, 32'd100, 32'd7);
    busy_cnt = 0;
    @(negedge clk);
    if (md__busy) busy_cnt++;
    @(posedge clk);
    #1;
    exp_q.push_back(32'd14);
    md__active = 1'b1;
    md__opcode = OP_MFLO;
    stall_cnt  = 0;
    guard      = 0;
    forever begin
      @(negedge clk);
      if (md__busy) busy_cnt++;
      if (!md__stall || guard > 100) break;
      stall_cnt++;
      guard++;
    end
    @(posedge clk);
    #1;
    md__active = 1'b0;
    check("divu_stall_cycles", stall_cnt, 32'd32);
    check("divu_busy_cycles", busy_cnt, 32'd33);
    read_expect(OP_MFHI, 32'd2);

    // Signed, overflow and divide-by-zero vectors
    for (int i = 0; i < 5; i++) begin
      issue(dv[i].op, dv[i].a, dv[i].b);
      read_expect(OP_MFLO, dv[i].lo);
      read_expect(OP_MFHI, dv[i].hi);
    end

    // MTHI held off during a divide while operands toggle
    issue(OP_DIV, 32'd1000, 32'hFFFF_FFFD);
    md__active = 1'b1;
    md__opcode = OP_MTHI;
    guard      = 0;
    forever begin
      if (!md__stall) begin
        rs_data = 32'h0000_1234;
        @(posedge clk);
        #1;
        break;
      end
      if (guard > 100) begin
        checks++;
        failures++;
        $display("FAIL mthi_timeout got=stalled expected=accepted");
        break;
      end
      rs_data = $urandom;
      rt_data = $urandom;
      guard++;
      @(posedge clk);
      #1;
    end
    md__active = 1'b0;
    read_expect(OP_MFHI, 32'h0000_1234);
    read_expect(OP_MFLO, 32'hFFFF_FEB3);

    // Back-to-back divides: the second uses operands at its own accept edge
    issue(OP_DIV, 32'd50, 32'd3);
    issue(OP_DIVU, 32'd100, 32'd7);
    read_expect(OP_MFLO, 32'd14);
    read_expect(OP_MFHI, 32'd2);

    // Reset asserted mid-divide
    issue(OP_DIVU, 32'd1000, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    rst_b = 1'b0;
    md__opcode = OP_MFHI;
    #1;
    check("midreset_busy", {31'd0, md__busy}, 32'd0);
    check("midreset_hi", md__rd_data, 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    read_expect(OP_MFHI, 32'd0);
    read_expect(OP_MFLO, 32'd0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_coprocessor.md
Name: muldiv_coprocessor

Overview:
- HI/LO arithmetic unit for the 18-447 MIPS core. Adds the divide path the existing multiplier lacks.
- MULT/MULTU/MTHI/MTLO complete in one cycle.
- DIV/DIVU use a 32-iteration restoring divider.
- The unit is the responder to the core's issue interface: the core issues ops and reads HI/LO; this block back-pressures the core with a combinational stall while a divide is in flight.

Parameters:
- DIV_ZERO_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
- clk  input  1  core clock.
- rst_b  input  1  asynchronous active-low reset.
- md__opcode  input  3  operation; encodings are the shared `MUL_MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU` defines.
- md__active  input  1  op valid this cycle.
- rs_data  input  32  dividend / multiplicand / MT source.
- rt_data  input  32  divisor / multiplier.
- md__rd_data  output  32  HI or LO for MFHI/MFLO.
- md__stall  output  1  core must hold its current op and retry next cycle.
- md__busy  output  1  divide in progress.

Behaviour:
- Reset (async, rst_b low): hi=0, lo=0, state=IDLE, iteration counter=0, md__busy=0. md__stall=0 whenever md__active=0. Reset asserted mid-divide aborts it; no partial result reaches HI/LO.
- States: IDLE, DIVIDE, FIXUP. md__busy = (state != IDLE).
- Stall: md__stall = md__active & md__busy. This is combinational, for any opcode. A stalled op has no effect; the core holds opcode and operands stable until stall drops. The op then executes in the first IDLE cycle.
- Accepting an op: an op is accepted at a posedge with md__active=1 and state=IDLE.
- MTHI / MTLO: hi or lo <= rs_data at that edge.
- MULT: {hi,lo} <= signed 64-bit rs*rt.
- MULTU: {hi,lo} <= unsigned 64-bit rs*rt. Both complete at the accepting edge.
- MFHI / MFLO (read path, combinational): md__rd_data = hi or lo when state=IDLE. Otherwise 32'hx. There is no register side effect.
- Divide issue (DIV/DIVU accepted):
  - Latch divisor magnitude, the quotient sign (rs[31]^rt[31]) and the remainder sign (rs[31]).
  - Initialise quotient register = dividend magnitude, partial remainder = 0, counter = 31.
  - Go to DIVIDE. DIVU treats the operands as unsigned and both signs as 0.
- DIVIDE: each cycle, shift {rem,quo} left 1 and trial-subtract the divisor from the 33-bit remainder. If the result is non-negative, keep it and set quo[0]=1; else quo[0]=0. When counter=0, go to FIXUP; otherwise decrement the counter.
- FIXUP (one cycle): negate quo if the quotient sign is set; negate rem if the remainder sign is set. Write lo<=quotient, hi<=remainder at this edge, then go to IDLE.
- Latency: accept edge E → results visible in hi/lo after edge E+33. md__busy is high for 33 cycles; an op issued at E+1 … E+33 stalls until the cycle after E+33.
- Divide by zero (rt==0, DIV or DIVU): the divider still runs its full 33 cycles. Result is lo=DIV_ZERO_LO, hi=rs_data (raw), overriding the sign fixup. No simulation $finish.
- Signed overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0. This is the natural 32-bit wrap, with no trap.
- Operand capture: operands are captured only at the accept edge; changes to rs_data/rt_data during DIVIDE are ignored.
- Back-to-back DIV: the second DIV stalls and is accepted in the first IDLE cycle. Its operands are those presented at that edge.

Test Plan:
- Reset then MFHI/MFLO → 0/0; assert rst_b low mid-DIV at cycle 10 → hi=lo=0, md__busy=0 immediately, no later write.
- MULT rs=0xFFFF_FFFE (−2), rt=3 → hi=0xFFFF_FFFF, lo=0xFFFF_FFFA after 1 edge; MULTU same operands → hi=0x2, lo=0xFFFF_FFFA.
- DIVU 100/7 → busy 33 cycles, then lo=14, hi=2. DIV −7/2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). DIV 7/−2 → lo=−3, hi=1.
- DIV 0x8000_0000/0xFFFF_FFFF → lo=0x8000_0000, hi=0. DIVU 5/0 → lo=0xFFFF_FFFF, hi=5. DIV −5/0 → lo=0xFFFF_FFFF, hi=0xFFFF_FFFB.
- MFLO issued 1 cycle after DIV 100/7 → md__stall high exactly 32 consecutive cycles, then read returns 14.
- MTHI 0x1234 issued during DIVIDE with rs_data toggling → held off by stall; after completion hi=0x1234 overwrites the divide remainder. Divide result unaffected by operand toggling.
